// File: rtl/sim_run_pkg.sv
// Shared types and constants for the simulation run controller and the benches that drive it.
package sim_run_pkg;

    localparam int SIM_RUN_STATE_W = 3;

    typedef enum logic [SIM_RUN_STATE_W-1:0] {
        S_HOLD    = 3'd0,
        S_RELEASE = 3'd1,
        S_RUN     = 3'd2,
        S_DONE    = 3'd3,
        S_TIMEOUT = 3'd4
    } sim_run_state_e;

    // Benches raise halt_in when a core stores to this address.
    localparam logic [31:0] HALT_IO_ADDR = 32'h0003_0004;

    function automatic logic is_terminal(input sim_run_state_e s);
        return (s == S_DONE) || (s == S_TIMEOUT);
    endfunction

endpackage

// File: rtl/sim_run_ctrl_sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at all ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !(&r_cnt)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller: staggered core reset release, run cycle count, halt/watchdog termination.
// Optional SIM_RUN_DUMP_WINDOW_EN adds dump_en_out, high for a window of RUN cycle counts.
module sim_run_ctrl
    import sim_run_pkg::*;
#(
    parameter int          N_CORES        = 1,
    parameter int          RST_CYCLES     = 25,
    parameter int          STAGGER        = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1500000000,
    parameter int          CNT_W          = 32
`ifdef SIM_RUN_DUMP_WINDOW_EN
    ,
    parameter int unsigned DUMP_START     = 0,
    parameter int unsigned DUMP_STOP      = 600
`endif
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [N_CORES-1:0] halt_in,
    input  logic               restart_in,
    output logic [N_CORES-1:0] core_rst_out,
    output logic               running_out,
    output logic               done_out,
    output logic               timeout_out,
`ifdef SIM_RUN_DUMP_WINDOW_EN
    output logic               dump_en_out,
`endif
    output logic [CNT_W-1:0]   cycle_cnt_out
);

    localparam int REL_LAST = STAGGER * (N_CORES - 1);
    localparam int PH_MAX   = (RST_CYCLES > REL_LAST) ? RST_CYCLES : REL_LAST;
    localparam int PH_W     = $clog2(PH_MAX + 2);

    sim_run_state_e     r_state;
    sim_run_state_e     w_state_next;
    logic [N_CORES-1:0] r_mask;
    logic [N_CORES-1:0] w_mask_next;
    logic [N_CORES-1:0] r_core_rst;
    logic [N_CORES-1:0] w_core_rst_next;
    logic               r_running;
    logic               r_done;
    logic               r_timeout;

    logic [PH_W-1:0]    w_phase;
    logic [PH_W-1:0]    w_rel_idx;
    logic               w_phase_en;
    logic               w_phase_clr;
    logic [CNT_W-1:0]   w_cycle;
    logic               w_cycle_en;
    logic               w_cycle_clr;
    logic               w_to_hit;

    sat_counter #(.W(PH_W)) u_phase_cnt (
        .i_clk   (clk_in),
        .i_rst_n (rst_n_in),
        .i_en    (w_phase_en),
        .i_clr   (w_phase_clr),
        .o_cnt   (w_phase)
    );

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .i_clk   (clk_in),
        .i_rst_n (rst_n_in),
        .i_en    (w_cycle_en),
        .i_clr   (w_cycle_clr),
        .o_cnt   (w_cycle)
    );

    generate
        if (TIMEOUT_CYCLES != 0) begin : g_wdog
            localparam logic [63:0] TO_LAST = 64'(TIMEOUT_CYCLES) - 64'd1;
            assign w_to_hit = (64'(w_cycle) == TO_LAST);
        end else begin : g_no_wdog
            assign w_to_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_mask_next  = r_mask;
        case (r_state)
            S_HOLD: begin
                if (w_phase == PH_W'(RST_CYCLES)) w_state_next = S_RELEASE;
            end
            S_RELEASE: begin
                if (w_phase == PH_W'(REL_LAST)) w_state_next = S_RUN;
            end
            S_RUN: begin
                w_mask_next = r_mask | (halt_in & ~r_core_rst);
                // A completing halt outranks a watchdog expiry in the same cycle.
                if (&w_mask_next)  w_state_next = S_DONE;
                else if (w_to_hit) w_state_next = S_TIMEOUT;
            end
            S_DONE, S_TIMEOUT: begin
                if (restart_in) begin
                    w_state_next = S_HOLD;
                    w_mask_next  = '0;
                end
            end
            default: w_state_next = S_HOLD;
        endcase

        w_phase_en  = (r_state == S_HOLD) || (r_state == S_RELEASE);
        w_phase_clr = (w_state_next != r_state);
        w_cycle_en  = (r_state == S_RUN) && (w_state_next == S_RUN);
        w_cycle_clr = is_terminal(r_state) && (w_state_next == S_HOLD);
    end

    // Cycles elapsed since RELEASE entry, as seen after the coming edge.
    assign w_rel_idx = (r_state == S_RELEASE) ? (w_phase + PH_W'(1)) : '0;

    generate
        for (genvar gi = 0; gi < N_CORES; gi++) begin : g_core_rst
            localparam logic [PH_W-1:0] REL_AT = PH_W'(STAGGER * gi);
            assign w_core_rst_next[gi] = (w_state_next == S_RELEASE) ? (w_rel_idx < REL_AT)
                                                                     : (w_state_next != S_RUN);
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= S_HOLD;
            r_mask     <= '0;
            r_core_rst <= '1;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_mask     <= w_mask_next;
            r_core_rst <= w_core_rst_next;
            r_running  <= (w_state_next == S_RUN);
            r_done     <= (w_state_next == S_DONE);
            r_timeout  <= (w_state_next == S_TIMEOUT);
        end
    end

`ifdef SIM_RUN_DUMP_WINDOW_EN
    logic [CNT_W-1:0] w_cycle_next;
    logic             w_dump_next;
    logic             r_dump_en;

    always_comb begin
        w_cycle_next = '0;
        if (r_state == S_RUN) begin
            w_cycle_next = (&w_cycle) ? w_cycle : (w_cycle + CNT_W'(1));
        end
        w_dump_next = (w_state_next == S_RUN)
                   && (64'(w_cycle_next) >= 64'(DUMP_START))
                   && (64'(w_cycle_next) <  64'(DUMP_STOP));
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_dump_en <= 1'b0;
        end else begin
            r_dump_en <= w_dump_next;
        end
    end

    assign dump_en_out = r_dump_en;
`endif

    assign core_rst_out  = r_core_rst;
    assign running_out   = r_running;
    assign done_out      = r_done;
    assign timeout_out   = r_timeout;
    assign cycle_cnt_out = w_cycle;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl with N_CORES=2, RST_CYCLES=4, STAGGER=3, TIMEOUT_CYCLES=20.
// Define SIM_RUN_DUMP_WINDOW_EN to also exercise dump_en_out with a 3..4 window.
module tb_sim_run_ctrl;

    logic        clk_in;
    logic        rst_n_in;
    logic [1:0]  halt_in;
    logic        restart_in;
    logic [1:0]  core_rst_out;
    logic        running_out;
    logic        done_out;
    logic        timeout_out;
    logic [31:0] cycle_cnt_out;
`ifdef SIM_RUN_DUMP_WINDOW_EN
    logic        dump_en_out;
`endif

    int n_cmp;
    int n_fail;

    sim_run_ctrl #(
        .N_CORES        (2),
        .RST_CYCLES     (4),
        .STAGGER        (3),
        .TIMEOUT_CYCLES (20),
        .CNT_W          (32)
`ifdef SIM_RUN_DUMP_WINDOW_EN
        ,
        .DUMP_START     (3),
        .DUMP_STOP      (5)
`endif
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .halt_in       (halt_in),
        .restart_in    (restart_in),
        .core_rst_out  (core_rst_out),
        .running_out   (running_out),
        .done_out      (done_out),
        .timeout_out   (timeout_out),
`ifdef SIM_RUN_DUMP_WINDOW_EN
        .dump_en_out   (dump_en_out),
`endif
        .cycle_cnt_out (cycle_cnt_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Status vector compared below: {core_rst[1:0], running, done, timeout}.
    function automatic logic [4:0] status();
        return {core_rst_out, running_out, done_out, timeout_out};
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Called just after the edge that plays "edge 0"; leaves the bench in RUN cycle 0.
    task automatic check_release_seq(input string name, input logic [1:0] halt_during);
        logic [4:0] exp_st;
        halt_in = halt_during;
        for (int k = 1; k <= 9; k++) begin
            step();
            restart_in = 1'b0;
            exp_st = (k < 5) ? 5'b11_0_0_0 : (k < 8) ? 5'b10_0_0_0
                   : (k < 9) ? 5'b00_0_0_0 : 5'b00_1_0_0;
            n_cmp++;
            if (status() !== exp_st) begin
                $display("FAIL %s edge %0d: status got %b expected %b", name, k, status(), exp_st);
                n_fail++;
            end
            if (k == 8) halt_in = 2'b00;
        end
        n_cmp++;
        if (cycle_cnt_out !== 32'd0) begin
            $display("FAIL %s first RUN count: got %0d expected 0", name, cycle_cnt_out);
            n_fail++;
        end
        $display("%s: release sequence checked through RUN entry", name);
    endtask

    task automatic test_reset();
        rst_n_in   = 1'b0;
        halt_in    = 2'b00;
        restart_in = 1'b0;
        step();
        step();
        n_cmp++;
        if (status() !== 5'b11_0_0_0 || cycle_cnt_out !== 32'd0) begin
            $display("FAIL reset_values: status %b cnt %0d expected 11000 cnt 0", status(), cycle_cnt_out);
            n_fail++;
        end
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        check_release_seq("reset_release", 2'b00);
    endtask

    task automatic test_halt_done();
        step();
        step();
        halt_in = 2'b01;
        step();
        halt_in = 2'b00;
        n_cmp++;
        if (status() !== 5'b00_1_0_0 || cycle_cnt_out !== 32'd3) begin
            $display("FAIL halt_partial: status %b cnt %0d expected 00100 cnt 3", status(), cycle_cnt_out);
            n_fail++;
        end
        step();
        step();
        step();
        halt_in = 2'b10;
        step();
        halt_in = 2'b00;
        n_cmp++;
        if (status() !== 5'b11_0_1_0 || cycle_cnt_out !== 32'd6) begin
            $display("FAIL halt_done: status %b cnt %0d expected 11010 cnt 6", status(), cycle_cnt_out);
            n_fail++;
        end
        step();
        step();
        n_cmp++;
        if (status() !== 5'b11_0_1_0 || cycle_cnt_out !== 32'd6) begin
            $display("FAIL done_hold: status %b cnt %0d expected 11010 cnt 6", status(), cycle_cnt_out);
            n_fail++;
        end
        $display("halt_done: done at count %0d", cycle_cnt_out);
    endtask

    task automatic test_restart_after_done();
        restart_in = 1'b1;
        step();
        restart_in = 1'b0;
        n_cmp++;
        if (status() !== 5'b11_0_0_0 || cycle_cnt_out !== 32'd0) begin
            $display("FAIL restart_done: status %b cnt %0d expected 11000 cnt 0", status(), cycle_cnt_out);
            n_fail++;
        end
        check_release_seq("restart_halt_ignored", 2'b11);
        step();
        step();
        n_cmp++;
        if (status() !== 5'b00_1_0_0 || cycle_cnt_out !== 32'd2) begin
            $display("FAIL pre_run_halt_ignored: status %b cnt %0d expected 00100 cnt 2", status(), cycle_cnt_out);
            n_fail++;
        end
    endtask

    // Enters at RUN cycle 2 (left there by the previous task).
    task automatic test_timeout();
        for (int k = 3; k <= 19; k++) begin
            step();
            n_cmp++;
            if (status() !== 5'b00_1_0_0 || cycle_cnt_out !== 32'(k)) begin
                $display("FAIL run_count: status %b cnt %0d expected 00100 cnt %0d", status(), cycle_cnt_out, k);
                n_fail++;
            end
        end
        step();
        n_cmp++;
        if (status() !== 5'b11_0_0_1 || cycle_cnt_out !== 32'd19) begin
            $display("FAIL timeout_hit: status %b cnt %0d expected 11001 cnt 19", status(), cycle_cnt_out);
            n_fail++;
        end
        halt_in = 2'b11;
        step();
        halt_in = 2'b00;
        n_cmp++;
        if (status() !== 5'b11_0_0_1 || cycle_cnt_out !== 32'd19) begin
            $display("FAIL timeout_hold: status %b cnt %0d expected 11001 cnt 19", status(), cycle_cnt_out);
            n_fail++;
        end
        $display("timeout: watchdog fired at count %0d", cycle_cnt_out);
    endtask

    task automatic test_restart_long_pulse();
        restart_in = 1'b1;
        step();
        n_cmp++;
        if (status() !== 5'b11_0_0_0 || cycle_cnt_out !== 32'd0) begin
            $display("FAIL restart_timeout: status %b cnt %0d expected 11000 cnt 0", status(), cycle_cnt_out);
            n_fail++;
        end
        check_release_seq("restart_long_pulse", 2'b00);
    endtask

    task automatic test_halt_timeout_same_cycle();
        for (int k = 0; k < 5; k++) step();
        halt_in = 2'b01;
        step();
        halt_in = 2'b00;
        for (int k = 6; k < 19; k++) step();
        n_cmp++;
        if (status() !== 5'b00_1_0_0 || cycle_cnt_out !== 32'd19) begin
            $display("FAIL before_boundary: status %b cnt %0d expected 00100 cnt 19", status(), cycle_cnt_out);
            n_fail++;
        end
        halt_in = 2'b10;
        step();
        halt_in = 2'b00;
        n_cmp++;
        if (status() !== 5'b11_0_1_0 || cycle_cnt_out !== 32'd19) begin
            $display("FAIL done_beats_timeout: status %b cnt %0d expected 11010 cnt 19", status(), cycle_cnt_out);
            n_fail++;
        end
        $display("halt_timeout_same_cycle: done=%0b timeout=%0b", done_out, timeout_out);
    endtask

    task automatic test_async_reset_mid_release();
        restart_in = 1'b1;
        step();
        restart_in = 1'b0;
        for (int k = 1; k <= 6; k++) step();
        n_cmp++;
        if (status() !== 5'b10_0_0_0) begin
            $display("FAIL mid_release: status %b expected 10000", status());
            n_fail++;
        end
        #3 rst_n_in = 1'b0;
        #1;
        n_cmp++;
        if (status() !== 5'b11_0_0_0 || cycle_cnt_out !== 32'd0) begin
            $display("FAIL async_reset_release: status %b cnt %0d expected 11000 cnt 0", status(), cycle_cnt_out);
            n_fail++;
        end
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        check_release_seq("after_async_release", 2'b00);
    endtask

    task automatic test_async_reset_mid_run();
        for (int k = 0; k < 4; k++) step();
        n_cmp++;
        if (cycle_cnt_out !== 32'd4) begin
            $display("FAIL mid_run_count: got %0d expected 4", cycle_cnt_out);
            n_fail++;
        end
        #3 rst_n_in = 1'b0;
        #1;
        n_cmp++;
        if (status() !== 5'b11_0_0_0 || cycle_cnt_out !== 32'd0) begin
            $display("FAIL async_reset_run: status %b cnt %0d expected 11000 cnt 0", status(), cycle_cnt_out);
            n_fail++;
        end
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        check_release_seq("after_async_run", 2'b00);
    endtask

`ifdef SIM_RUN_DUMP_WINDOW_EN
    task automatic test_dump_window();
        logic exp_dump;
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) step();
            exp_dump = (k >= 3) && (k < 5);
            n_cmp++;
            if (dump_en_out !== exp_dump) begin
                $display("FAIL dump_window cnt %0d: got %b expected %b", cycle_cnt_out, dump_en_out, exp_dump);
                n_fail++;
            end
        end
        $display("dump_window: checked counts 0..7");
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_halt_done();
        test_restart_after_done();
        test_timeout();
        test_restart_long_pulse();
        test_halt_timeout_same_cycle();
        test_async_reset_mid_release();
        test_async_reset_mid_run();
`ifdef SIM_RUN_DUMP_WINDOW_EN
        test_dump_window();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
